// File: rtl/ray_march_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ray_march_ctrl_pkg                                            |
// | Purpose  : Shared vector package. Holds the Q16.16 scalar type (fp), the |
// |            three-component vector type (vec3), the fraction-width        |
// |            constant and the fixed-point multiply used by the march       |
// |            datapath.                                                     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ray_march_ctrl_pkg;

    // Number of fraction bits in the Q16.16 format.
    localparam int c_frac_w = 16;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    // Full-precision signed product, rescaled back to Q16.16 by an arithmetic
    // shift; the upper bits are dropped, so out-of-range results wrap.
    function automatic fp fp_mul(input fp a, input fp b);
        logic signed [63:0] w_prod;
        w_prod = 64'(a) * 64'(b);
        return fp'(w_prod >>> c_frac_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ray_march_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ray_march_ctrl_if                                             |
// | Purpose  : Bundles the ray start handshake, the SDF evaluation channel   |
// |            and the result handshake of the ray march controller.         |
// | Modports : master - environment side (offers rays, returns SDF results,  |
// |                     consumes march results)                              |
// |            slave  - controller side                                      |
// | Config   : RAY_MARCH_STEP_COUNT_EN adds the 8-bit step_count signal.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ray_march_ctrl_if;
    import ray_march_ctrl_pkg::*;

    // Ray start handshake
    logic       start_valid;
    logic       start_ready;
    vec3        ray_origin;
    vec3        ray_dir;
    // SDF evaluation channel
    logic       sdf_valid_in;
    vec3        sdf_p;
    logic       sdf_valid_out;
    fp          sdf_dist;
    // Result handshake
    logic       result_valid;
    logic       result_ready;
    logic       hit;
    vec3        hit_pos;
    fp          total_dist;
`ifdef RAY_MARCH_STEP_COUNT_EN
    logic [7:0] step_count;
`endif

`ifdef RAY_MARCH_STEP_COUNT_EN
    modport master (
        output start_valid, ray_origin, ray_dir, sdf_valid_out, sdf_dist, result_ready,
        input  start_ready, sdf_valid_in, sdf_p, result_valid, hit, hit_pos, total_dist,
               step_count
    );
    modport slave (
        input  start_valid, ray_origin, ray_dir, sdf_valid_out, sdf_dist, result_ready,
        output start_ready, sdf_valid_in, sdf_p, result_valid, hit, hit_pos, total_dist,
               step_count
    );
`else
    modport master (
        output start_valid, ray_origin, ray_dir, sdf_valid_out, sdf_dist, result_ready,
        input  start_ready, sdf_valid_in, sdf_p, result_valid, hit, hit_pos, total_dist
    );
    modport slave (
        input  start_valid, ray_origin, ray_dir, sdf_valid_out, sdf_dist, result_ready,
        output start_ready, sdf_valid_in, sdf_p, result_valid, hit, hit_pos, total_dist
    );
`endif

endinterface
`default_nettype wire

// File: rtl/ray_march_ctrl_vec3_scale_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec3_scale_add                                                |
// | Purpose  : Combinational q = p + dir * s on Q16.16 vectors. Each         |
// |            component uses the package fixed-point multiply; additions    |
// |            wrap. Intended for reuse by other vector stages.              |
// | Ports    : p   (in)  base point                                          |
// |            dir (in)  direction vector                                    |
// |            s   (in)  scalar step                                         |
// |            q   (out) advanced point                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vec3_scale_add
    import ray_march_ctrl_pkg::*;
(
    input  vec3 p,
    input  vec3 dir,
    input  fp   s,
    output vec3 q
);

    assign q.x = p.x + fp_mul(dir.x, s);
    assign q.y = p.y + fp_mul(dir.y, s);
    assign q.z = p.z + fp_mul(dir.z, s);

endmodule
`default_nettype wire

// File: rtl/ray_march_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ray_march_ctrl                                                |
// | Purpose  : Sphere-tracing controller. Accepts a ray, repeatedly queries  |
// |            an external SDF stage at the current march point, advances    |
// |            along the ray by the returned distance and reports hit/miss,  |
// |            final point and distance travelled.                           |
// | Ports    : clk  (in) clock, rising edge                                  |
// |            rst  (in) synchronous active-high reset                       |
// |            bus  (slave modport of ray_march_ctrl_if): start handshake,   |
// |                 SDF launch/return channel, result handshake              |
// | Params   : MAX_STEPS (1..255), EPSILON (hit threshold, Q16.16),          |
// |            MAX_DIST (travelled-distance miss threshold, Q16.16)          |
// | Config   : RAY_MARCH_STEP_COUNT_EN drives bus.step_count with the number |
// |            of SDF evaluations used by the ray.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ray_march_ctrl
    import ray_march_ctrl_pkg::*;
#(
    parameter int MAX_STEPS = 64,
    parameter fp  EPSILON   = 32'h0000_0042,
    parameter fp  MAX_DIST  = 32'h0064_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ray_march_ctrl_if.slave  bus
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_issue  = 3'd1;
    localparam logic [2:0] c_wait   = 3'd2;
    localparam logic [2:0] c_update = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    localparam logic [7:0] c_max_steps = 8'(MAX_STEPS);

    logic [2:0] r_state;
    vec3        r_p;
    vec3        r_dir;
    fp          r_dist;
    fp          r_total;
    logic [7:0] r_step;
    logic       r_start_ready;
    logic       r_sdf_valid_in;
    vec3        r_sdf_p;
    logic       r_result_valid;
    logic       r_hit;

    vec3        w_p_next;
    fp          w_total_next;
    logic       w_is_hit;
    logic       w_is_miss;

    vec3_scale_add u_advance (
        .p   (r_p),
        .dir (r_dir),
        .s   (r_dist),
        .q   (w_p_next)
    );

    assign w_total_next = r_total + r_dist;
    // Signed compare: a negative distance (point inside the surface) is a hit.
    assign w_is_hit     = (r_dist < EPSILON);
    // Step counter already includes the evaluation just consumed.
    assign w_is_miss    = (w_total_next > MAX_DIST) || (r_step == c_max_steps);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_idle;
            r_p            <= '0;
            r_dir          <= '0;
            r_dist         <= '0;
            r_total        <= '0;
            r_step         <= '0;
            r_start_ready  <= 1'b1;
            r_sdf_valid_in <= 1'b0;
            r_sdf_p        <= '0;
            r_result_valid <= 1'b0;
            r_hit          <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start_valid) begin
                        r_p           <= bus.ray_origin;
                        r_dir         <= bus.ray_dir;
                        r_total       <= '0;
                        r_step        <= '0;
                        r_hit         <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_state       <= c_issue;
                    end
                end
                c_issue: begin
                    r_sdf_valid_in <= 1'b1;
                    r_sdf_p        <= r_p;
                    r_step         <= r_step + 8'd1;
                    r_state        <= c_wait;
                end
                c_wait: begin
                    // Launch strobe lasts exactly one cycle.
                    r_sdf_valid_in <= 1'b0;
                    if (bus.sdf_valid_out) begin
                        r_dist  <= bus.sdf_dist;
                        r_state <= c_update;
                    end
                end
                c_update: begin
                    if (w_is_hit) begin
                        r_hit          <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= c_done;
                    end else begin
                        r_p     <= w_p_next;
                        r_total <= w_total_next;
                        if (w_is_miss) begin
                            r_hit          <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_state        <= c_done;
                        end else begin
                            r_state <= c_issue;
                        end
                    end
                end
                c_done: begin
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_state        <= c_idle;
                    end
                end
                default: begin
                    r_sdf_valid_in <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                    r_state        <= c_idle;
                end
            endcase
        end
    end

    assign bus.start_ready  = r_start_ready;
    assign bus.sdf_valid_in = r_sdf_valid_in;
    assign bus.sdf_p        = r_sdf_p;
    assign bus.result_valid = r_result_valid;
    assign bus.hit          = r_hit;
    assign bus.hit_pos      = r_p;
    assign bus.total_dist   = r_total;
`ifdef RAY_MARCH_STEP_COUNT_EN
    assign bus.step_count   = r_step;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_march_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ray_march_ctrl                                             |
// | Purpose  : Directed bench for ray_march_ctrl. Three controller instances |
// |            (default, MAX_DIST=20.0, MAX_STEPS=1) each paired with a      |
// |            behavioural unit-sphere SDF of random latency 1..4.           |
// | Config   : RAY_MARCH_STEP_COUNT_EN enables step_count checks.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ray_march_ctrl;
    import ray_march_ctrl_pkg::*;

    localparam int c_n   = 3;
    localparam fp  c_0   = 32'h0000_0000;
    localparam fp  c_1   = 32'h0001_0000;
    localparam fp  c_m1  = 32'hFFFF_0000;
    localparam fp  c_2   = 32'h0002_0000;
    localparam fp  c_3   = 32'h0003_0000;
    localparam fp  c_m3  = 32'hFFFD_0000;
    localparam fp  c_4   = 32'h0004_0000;
    localparam fp  c_5   = 32'h0005_0000;
    localparam fp  c_m5  = 32'hFFFB_0000;
    localparam fp  c_20  = 32'h0014_0000;
    localparam fp  c_100 = 32'h0064_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [c_n-1:0] sv;
    logic [c_n-1:0] rr;
    logic [c_n-1:0] rv;
    logic [c_n-1:0] sr;
    logic [c_n-1:0] hit_a;
    logic [c_n-1:0] svi;
    vec3            org;
    vec3            dirv;
    vec3            hp [c_n];
    fp              td [c_n];
`ifdef RAY_MARCH_STEP_COUNT_EN
    logic [7:0]     sc [c_n];
`endif

    int lat    = 1;
    int checks = 0;
    int errors = 0;

    function automatic vec3 mk(input fp x, input fp y, input fp z);
        vec3 v;
        v.x = x;
        v.y = y;
        v.z = z;
        return v;
    endfunction

    // Unit sphere at the origin: |p| - 1, evaluated in real arithmetic.
    function automatic fp sdf_sphere(input vec3 p);
        real x, y, z, d;
        x = $itor(p.x) / 65536.0;
        y = $itor(p.y) / 65536.0;
        z = $itor(p.z) / 65536.0;
        d = $sqrt(x * x + y * y + z * z) - 1.0;
        return fp'($rtoi(d * 65536.0));
    endfunction

    for (genvar i = 0; i < c_n; i++) begin : g_dut
        ray_march_ctrl_if bus ();

        logic vo   = 1'b0;
        fp    d    = '0;
        logic busy = 1'b0;
        int   cnt  = 0;
        vec3  q    = '0;

        assign bus.start_valid   = sv[i];
        assign bus.ray_origin    = org;
        assign bus.ray_dir       = dirv;
        assign bus.result_ready  = rr[i];
        assign bus.sdf_valid_out = vo;
        assign bus.sdf_dist      = d;
        assign rv[i]    = bus.result_valid;
        assign sr[i]    = bus.start_ready;
        assign hit_a[i] = bus.hit;
        assign svi[i]   = bus.sdf_valid_in;
        assign hp[i]    = bus.hit_pos;
        assign td[i]    = bus.total_dist;
`ifdef RAY_MARCH_STEP_COUNT_EN
        assign sc[i]    = bus.step_count;
`endif

        ray_march_ctrl #(
            .MAX_STEPS ((i == 2) ? 1 : 64),
            .MAX_DIST  ((i == 1) ? c_20 : c_100)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Behavioural SDF stage; deliberately ignores rst so a late answer
        // can arrive after the controller has been reset.
        always @(posedge clk) begin
            vo <= 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    vo   <= 1'b1;
                    d    <= sdf_sphere(q);
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (bus.sdf_valid_in) begin
                busy <= 1'b1;
                cnt  <= lat - 1;
                q    <= bus.sdf_p;
            end
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_ray(input int k, input vec3 o, input vec3 dv);
        @(negedge clk);
        org   = o;
        dirv  = dv;
        sv[k] = 1'b1;
        @(negedge clk);
        sv[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (rv[k]) ok = 1'b1;
        end
        check({tag, "_done"}, ok, 1'b1);
    endtask

    task automatic accept(input int k, input string tag);
        @(negedge clk);
        rr[k] = 1'b1;
        @(negedge clk);
        rr[k] = 1'b0;
        check({tag, "_accept"}, rv[k], 1'b0);
    endtask

    initial begin
        logic found;
        sv   = '0;
        rr   = '0;
        org  = '0;
        dirv = '0;
        lat  = $urandom_range(1, 4);
        $display("sdf latency = %0d", lat);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_start_ready", sr[0], 1'b1);
        check("rst_result_valid", rv[0], 1'b0);
        check("rst_hit", hit_a[0], 1'b0);
        check("rst_sdf_valid_in", svi[0], 1'b0);
        check("rst_hit_pos", hp[0], mk(c_0, c_0, c_0));
        check("rst_total_dist", td[0], c_0);
`ifdef RAY_MARCH_STEP_COUNT_EN
        check("rst_step_count", sc[0], 8'd0);
`endif

        // Hit from (0,0,-5) along +z, then hold result under backpressure
        start_ray(0, mk(c_0, c_0, c_m5), mk(c_0, c_0, c_1));
        check("hit_busy_ready", sr[0], 1'b0);
        wait_result(0, "hit");
        check("hit_flag", hit_a[0], 1'b1);
        check("hit_pos", hp[0], mk(c_0, c_0, c_m1));
        check("hit_dist", td[0], c_4);
`ifdef RAY_MARCH_STEP_COUNT_EN
        check("hit_steps", sc[0], 8'd2);
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", rv[0], 1'b1);
            check("bp_hit", hit_a[0], 1'b1);
            check("bp_pos", hp[0], mk(c_0, c_0, c_m1));
            check("bp_dist", td[0], c_4);
        end
        accept(0, "hit");

        // Busy: a second start offered mid-march must be dropped
        start_ray(0, mk(c_m3, c_0, c_0), mk(c_1, c_0, c_0));
        @(negedge clk);
        org   = mk(c_0, c_0, c_m5);
        dirv  = mk(c_0, c_0, c_1);
        sv[0] = 1'b1;
        repeat (3) @(negedge clk);
        sv[0] = 1'b0;
        wait_result(0, "busy");
        check("busy_hit", hit_a[0], 1'b1);
        check("busy_pos", hp[0], mk(c_m1, c_0, c_0));
        check("busy_dist", td[0], c_2);
        accept(0, "busy");
        repeat (5) @(negedge clk);
        check("no_queue_valid", rv[0], 1'b0);
        check("no_queue_ready", sr[0], 1'b1);

        // Negative direction component
        start_ray(0, mk(c_0, c_0, c_3), mk(c_0, c_0, c_m1));
        wait_result(0, "negdir");
        check("negdir_hit", hit_a[0], 1'b1);
        check("negdir_pos", hp[0], mk(c_0, c_0, c_1));
        check("negdir_dist", td[0], c_2);
        accept(0, "negdir");

        // Starting inside the sphere: distance -1.0 is a hit on step 1
        start_ray(0, mk(c_0, c_0, c_0), mk(c_0, c_0, c_1));
        wait_result(0, "inside");
        check("inside_hit", hit_a[0], 1'b1);
        check("inside_pos", hp[0], mk(c_0, c_0, c_0));
        check("inside_dist", td[0], c_0);
`ifdef RAY_MARCH_STEP_COUNT_EN
        check("inside_steps", sc[0], 8'd1);
`endif
        accept(0, "inside");

        // Miss by distance on the MAX_DIST=20 instance
        start_ray(1, mk(c_0, c_5, c_m5), mk(c_0, c_0, c_1));
        wait_result(1, "miss");
        check("miss_hit", hit_a[1], 1'b0);
        check("miss_dist_gt20", (td[1] > c_20), 1'b1);
        accept(1, "miss");

        // Step limit on the MAX_STEPS=1 instance
        start_ray(2, mk(c_0, c_0, c_m5), mk(c_0, c_0, c_1));
        wait_result(2, "steplim");
        check("steplim_hit", hit_a[2], 1'b0);
        check("steplim_dist", td[2], c_4);
        check("steplim_pos", hp[2], mk(c_0, c_0, c_m1));
`ifdef RAY_MARCH_STEP_COUNT_EN
        check("steplim_steps", sc[2], 8'd1);
`endif
        accept(2, "steplim");

        // Reset while waiting on the SDF; its late answer must be ignored
        start_ray(0, mk(c_0, c_0, c_m5), mk(c_0, c_0, c_1));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (svi[0]) found = 1'b1;
            else @(negedge clk);
        end
        check("rstwait_launch_seen", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_ready", sr[0], 1'b1);
        check("rstwait_valid", rv[0], 1'b0);
        check("rstwait_dist", td[0], c_0);
        repeat (8) @(negedge clk);
        check("late_sdf_ready", sr[0], 1'b1);
        check("late_sdf_valid", rv[0], 1'b0);
        check("late_sdf_pos", hp[0], mk(c_0, c_0, c_0));
        check("late_sdf_launch", svi[0], 1'b0);
        start_ray(0, mk(c_0, c_0, c_m5), mk(c_0, c_0, c_1));
        wait_result(0, "after_rst");
        check("after_rst_hit", hit_a[0], 1'b1);
        check("after_rst_pos", hp[0], mk(c_0, c_0, c_m1));
        check("after_rst_dist", td[0], c_4);
`ifdef RAY_MARCH_STEP_COUNT_EN
        check("after_rst_steps", sc[0], 8'd2);
`endif
        accept(0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_march_ctrl.md
RAY_MARCH_CTRL -- requirements
Module: ray_march_ctrl

Interface
REQ-001 Parameter MAX_STEPS, default 64: maximum SDF evaluations per ray, 1..255.
REQ-002 Parameter EPSILON, default fp 0.001 (Q16.16 32'h0000_0042): hit threshold.
REQ-003 Parameter MAX_DIST, default fp 100.0: travelled-distance miss threshold.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start_valid  in  1  new ray offered.
REQ-007 start_ready  out  1  controller idle and accepting a ray.
REQ-008 ray_origin  in  vec3  ray start point.
REQ-009 ray_dir  in  vec3  unit direction; not renormalised.
REQ-010 sdf_valid_in  out  1  one-cycle pulse launching an SDF evaluation.
REQ-011 sdf_p  out  vec3  query point; held stable from launch until sdf_valid_out.
REQ-012 sdf_valid_out  in  1  SDF result valid; latency arbitrary, at least 1 cycle.
REQ-013 sdf_dist  in  fp  signed distance returned by the SDF stage.
REQ-014 result_valid  out  1  result available; held until accepted.
REQ-015 result_ready  in  1  consumer accepts the result.
REQ-016 hit  out  1  1 = surface hit, 0 = miss.
REQ-017 hit_pos  out  vec3  final march point.
REQ-018 total_dist  out  fp  accumulated distance travelled.

Function
REQ-019 The FSM states SHALL be IDLE, ISSUE, WAIT, UPDATE, DONE.
REQ-020 IDLE: start_ready=1; start_valid -> latch origin into p and dir, zero total_dist and step counter, go to ISSUE.
REQ-021 ISSUE: sdf_valid_in=1 for exactly one cycle, sdf_p=p, increment step counter, go to WAIT.
REQ-022 WAIT: register sdf_dist when sdf_valid_out=1, go to UPDATE; sdf_valid_out in any other state is ignored.
REQ-023 UPDATE priority 1, hit: dist < EPSILON (signed; negative counts as hit) -> hit=1, p unchanged, go to DONE.
REQ-024 UPDATE priority 2, advance: p += dir*dist per component; total_dist += dist.
REQ-025 UPDATE priority 3, miss: new total_dist > MAX_DIST or step counter == MAX_STEPS -> hit=0, go to DONE; otherwise go to ISSUE.
REQ-026 Multiply: signed 32x32 -> 64 bit, arithmetic shift right by 16, truncate to fp; additions wrap (no saturation).
REQ-027 DONE: result_valid=1 with outputs stable; result_valid && result_ready -> IDLE.
REQ-028 Latency per step: 3 cycles plus SDF latency; start to result_valid = N*(3+L_sdf)+1 cycles.
REQ-029 start_valid while start_ready=0 SHALL be ignored, with no queueing.

Reset
REQ-030 rst -> IDLE; start_ready=1; sdf_valid_in, result_valid, hit = 0; sdf_p, hit_pos, total_dist, step counter = 0.
REQ-031 rst mid-ray SHALL abandon the ray; a late sdf_valid_out after reset SHALL be ignored.

Configuration
REQ-032 RAY_MARCH_STEP_COUNT_EN defined: extra output step_count (out, 8 bits) = SDF evaluations used, valid with result_valid.
REQ-033 RAY_MARCH_STEP_COUNT_EN undefined: the port is absent and behaviour is otherwise identical.

Structure
REQ-034 fp, vec3, the Q16.16 fraction-width constant and the fp multiply function SHALL live in the shared vector package.
REQ-035 One sub-module, vec3_scale_add (p + dir*s, combinational), is natural and SHALL be reused by other stages.

Verification (bench: behavioural SDF, unit sphere at origin, latency L=1..4, randomised per run)
REQ-036 Hit: origin (0,0,-5), dir (0,0,1) -> hit=1, hit_pos (0,0,-1) ±1 LSB, total_dist 4.0, step_count=2.
REQ-037 Miss: origin (0,5,-5), dir (0,0,1), MAX_DIST=20 -> hit=0, total_dist > 20.0.
REQ-038 Step limit: MAX_STEPS=1, origin (0,0,-5) -> hit=0, step_count=1, total_dist 4.0.
REQ-039 Inside start: origin (0,0,0) -> sdf_dist -1.0, hit=1 after 1 step, hit_pos (0,0,0).
REQ-040 Backpressure and busy: result_ready low for 10 cycles -> result_valid and outputs stable; start_valid during a march is ignored.
REQ-041 Reset mid-WAIT, SDF then returns -> no state change, start_ready=1, next ray correct.
